// File: rtl/i2c_reg_access.sv
// Register read/write sequencer driving a byte-level I2C master through a
// strobe/ready/done command handshake, with NACK handling and a per-command watchdog.
module i2c_reg_access #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic       resp_valid,
   output logic [7:0] rd_data,
   output logic [1:0] err,
   output logic       m_write,
   output logic [2:0] m_cmd,
   output logic [7:0] m_data_in,
   input  logic       m_ready,
   input  logic       m_done_tick,
   input  logic       m_ack,
   input  logic [7:0] m_data_out
);

   localparam logic [2:0] CMD_START = 3'd0, CMD_RESTART = 3'd1, CMD_STOP = 3'd2,
                          CMD_READ  = 3'd3, CMD_WRITE   = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_CMD, S_RESP} state_t;
   typedef struct packed {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] ra;
      logic [7:0] data;
   } req_t;

   state_t      state_q, state_d;
   req_t        req_q, req_d;
   logic [2:0]  step_q, step_d;
   logic [15:0] wd_q, wd_d, wd_next;
   logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
   logic        m_write_q, m_write_d;
   logic [2:0]  m_cmd_q, m_cmd_d;
   logic [7:0]  m_data_in_q, m_data_in_d, rd_data_q, rd_data_d;
   logic [1:0]  err_q, err_d;
   logic [2:0]  seq_cmd, last_step;
   logic [7:0]  seq_data;
   logic        addr_step, cmd_done;

   // Command/byte for the current step; read and write share the first three steps.
   always_comb begin
      seq_cmd  = CMD_STOP;
      seq_data = 8'h00;
      case (step_q)
         3'd0: seq_cmd = CMD_START;
         3'd1: begin seq_cmd = CMD_WRITE; seq_data = {req_q.dev, 1'b0}; end
         3'd2: begin seq_cmd = CMD_WRITE; seq_data = req_q.ra; end
         3'd3: begin
            if (req_q.rw) seq_cmd = CMD_RESTART;
            else begin seq_cmd = CMD_WRITE; seq_data = req_q.data; end
         end
         3'd4: if (req_q.rw) begin seq_cmd = CMD_WRITE; seq_data = {req_q.dev, 1'b1}; end
         3'd5: begin seq_cmd = CMD_READ; seq_data = 8'h01; end
         default: seq_cmd = CMD_STOP;
      endcase
   end

   assign last_step = req_q.rw ? 3'd6 : 3'd4;
   assign addr_step = (step_q == 3'd1) || (req_q.rw && step_q == 3'd4);

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      step_d       = step_q;
      wd_d         = wd_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      m_write_d    = 1'b0;
      m_cmd_d      = m_cmd_q;
      m_data_in_d  = m_data_in_q;
      rd_data_d    = rd_data_q;
      err_d        = err_q;
      wd_next      = wd_q + 16'd1;
      cmd_done     = 1'b0;
      case (state_q)
         S_IDLE: if (req_valid && req_ready_q) begin
            req_d       = '{rw: req_rw, dev: dev_addr, ra: reg_addr, data: wr_data};
            step_d      = 3'd0;
            err_d       = 2'b00;
            rd_data_d   = 8'h00;
            req_ready_d = 1'b0;
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            wd_d = 16'd0;
            if (m_ready) begin
               m_write_d   = 1'b1;
               m_cmd_d     = seq_cmd;
               m_data_in_d = seq_data;
               state_d     = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            wd_d = wd_next;
            if (!m_ready) state_d = S_WAIT_CMD;
            else if (wd_next == TIMEOUT_CYCLES) begin
               state_d = S_RESP; resp_valid_d = 1'b1; err_d = 2'b11;
            end
         end
         S_WAIT_CMD: begin
            wd_d     = wd_next;
            cmd_done = (m_cmd_q == CMD_WRITE || m_cmd_q == CMD_READ) ? m_done_tick : m_ready;
            if (cmd_done) begin
               if (m_cmd_q == CMD_READ) rd_data_d = m_data_out;
               // A NACKed byte jumps straight to STOP so the bus is released cleanly.
               if (m_cmd_q == CMD_WRITE && m_ack) begin
                  err_d   = addr_step ? 2'b01 : 2'b10;
                  step_d  = last_step;
                  state_d = S_ISSUE;
               end else if (step_q == last_step) begin
                  state_d = S_RESP; resp_valid_d = 1'b1;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end else if (wd_next == TIMEOUT_CYCLES) begin
               state_d = S_RESP; resp_valid_d = 1'b1; err_d = 2'b11;
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_q        <= '0;
         step_q       <= 3'd0;
         wd_q         <= 16'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         m_write_q    <= 1'b0;
         m_cmd_q      <= 3'd0;
         m_data_in_q  <= 8'h00;
         rd_data_q    <= 8'h00;
         err_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         step_q       <= step_d;
         wd_q         <= wd_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         m_write_q    <= m_write_d;
         m_cmd_q      <= m_cmd_d;
         m_data_in_q  <= m_data_in_d;
         rd_data_q    <= rd_data_d;
         err_q        <= err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign m_write    = m_write_q;
   assign m_cmd      = m_cmd_q;
   assign m_data_in  = m_data_in_q;
   assign rd_data    = rd_data_q;
   assign err        = err_q;

endmodule

// File: tb/tb_i2c_reg_access.sv
// Scoreboard bench: a behavioural I2C master/slave model answers commands, expected
// command traces and responses are queued at request time and checked by monitors.
module tb_i2c_reg_access;
   localparam logic [2:0] C_START = 3'd0, C_RESTART = 3'd1, C_STOP = 3'd2,
                          C_READ  = 3'd3, C_WRITE   = 3'd4;

   typedef struct {
      logic [1:0] err;
      logic [7:0] rd;
      bit         tmo;
   } resp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0, req_rw = 1'b0;
   logic [6:0] dev_addr = '0;
   logic [7:0] reg_addr = '0, wr_data = '0;
   logic       req_ready, resp_valid, m_write;
   logic [7:0] rd_data, m_data_in;
   logic [1:0] err;
   logic [2:0] m_cmd;
   logic       m_ready = 1'b1, m_done_tick = 1'b0, m_ack = 1'b0;
   logic [7:0] m_data_out = 8'h00;

   i2c_reg_access #(.TIMEOUT_CYCLES(16'd100)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .resp_valid(resp_valid), .rd_data(rd_data), .err(err),
      .m_write(m_write), .m_cmd(m_cmd), .m_data_in(m_data_in),
      .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_data_out(m_data_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, last_wr_cyc = 0;
   logic [10:0] exp_trace[$];
   resp_t       exp_resp[$];

   // Per-transaction slave behaviour: which WRITE byte (1-based) gets NACKed, read byte.
   int         nack_at = 0;
   logic [7:0] slave_byte = 8'h00;
   bit         hang = 1'b0;
   int         force_delay = 0;
   bit         restart_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Master model: takes a command on m_write, drops ready, answers after a delay.
   bit         mbusy = 1'b0;
   logic [2:0] mcur;
   int         mcnt, wcount;
   always @(negedge clk) begin
      logic [10:0] e;
      m_done_tick = 1'b0;
      if (reset) begin
         m_ready = 1'b1; mbusy = 1'b0; m_ack = 1'b0; restart_busy = 1'b0;
      end else if (!mbusy) begin
         if (m_write) begin
            last_wr_cyc = cyc;
            if (exp_trace.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL trace_extra: got cmd %0d data %0h expected none", m_cmd, m_data_in);
            end else begin
               e = exp_trace.pop_front();
               check("trace_cmd", m_cmd, e[10:8]);
               if (e[10:8] == C_WRITE || e[10:8] == C_READ) check("trace_data", m_data_in, e[7:0]);
            end
            mbusy = 1'b1; mcur = m_cmd; m_ready = 1'b0;
            mcnt = (force_delay != 0) ? force_delay : $urandom_range(1, 4);
            if (m_cmd == C_START) wcount = 0;
            restart_busy = (m_cmd == C_RESTART);
         end else if ($urandom_range(0, 7) == 0) begin
            // stray status outside a command wait must be ignored
            m_done_tick = 1'b1; m_ack = 1'($urandom_range(0, 1)); m_data_out = 8'($urandom);
         end
      end else if (hang && (mcur == C_WRITE || mcur == C_READ)) begin
         m_ready = 1'b0;
      end else if (mcnt > 1) begin
         mcnt--;
      end else begin
         mbusy = 1'b0; m_ready = 1'b1; restart_busy = 1'b0;
         if (mcur == C_WRITE) begin
            wcount++;
            m_done_tick = 1'b1; m_ack = (wcount == nack_at);
         end else if (mcur == C_READ) begin
            m_done_tick = 1'b1; m_ack = 1'($urandom_range(0, 1)); m_data_out = slave_byte;
         end
      end
   end

   // Response monitor.
   logic [1:0] hold_err = 2'b00;
   logic [7:0] hold_rd = 8'h00;
   always @(negedge clk) begin
      resp_t r;
      if (reset) begin
         hold_err = 2'b00; hold_rd = 8'h00;
      end else if (resp_valid) begin
         if (exp_resp.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL resp_extra: got err %0d rd %0h expected no response", err, rd_data);
         end else begin
            r = exp_resp.pop_front();
            check("resp_err", err, r.err);
            check("resp_rd", rd_data, r.rd);
            check("ready_low_in_resp", req_ready, 1'b0);
            if (r.tmo) check("timeout_latency", cyc - last_wr_cyc, 100);
            hold_err = r.err; hold_rd = r.rd;
         end
      end else if (req_ready) begin
         check("hold_err", err, hold_err);
         check("hold_rd", rd_data, hold_rd);
      end
   end

   function automatic logic [10:0] tr(input logic [2:0] c, input logic [7:0] d);
      return {c, d};
   endfunction

   // Reference: expected bus trace and response from the transaction's rules.
   task automatic model(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int nk, input logic [7:0] sb, input bit tmo);
      resp_t r;
      r.tmo = tmo; r.rd = 8'h00; r.err = 2'b00;
      exp_trace.push_back(tr(C_START, 0));
      exp_trace.push_back(tr(C_WRITE, {dev, 1'b0}));
      if (tmo) r.err = 2'b11;
      else if (nk == 1) r.err = 2'b01;
      else begin
         exp_trace.push_back(tr(C_WRITE, ra));
         if (nk == 2) r.err = 2'b10;
         else if (!rw) begin
            exp_trace.push_back(tr(C_WRITE, wd));
            if (nk == 3) r.err = 2'b10;
         end else begin
            exp_trace.push_back(tr(C_RESTART, 0));
            exp_trace.push_back(tr(C_WRITE, {dev, 1'b1}));
            if (nk == 3) r.err = 2'b01;
            else begin
               exp_trace.push_back(tr(C_READ, 8'h01));
               r.rd = sb;
            end
         end
      end
      if (!tmo) exp_trace.push_back(tr(C_STOP, 0));
      exp_resp.push_back(r);
   endtask

   task automatic issue(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int nk, input logic [7:0] sb, input bit tmo);
      int t = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      while (!req_ready && t < 3000) begin @(negedge clk); t++; end
      if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
      nack_at = nk; slave_byte = sb;
      model(rw, dev, ra, wd, nk, sb, tmo);
      req_valid = 1'b1; req_rw = rw; dev_addr = dev; reg_addr = ra; wr_data = wd;
      @(negedge clk);
      // busy-time requests carry garbage that must never be latched
      repeat (3) begin
         req_rw = 1'($urandom); dev_addr = 7'($urandom);
         reg_addr = 8'($urandom); wr_data = 8'($urandom);
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_resp.size() != 0 && t < 5000) begin @(negedge clk); t++; end
      check(name, exp_resp.size(), 0);
   endtask

   initial begin
      int t;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_m_write", m_write, 1'b0);
      check("rst_m_cmd", m_cmd, 3'd0);
      check("rst_m_data_in", m_data_in, 8'h00);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_err", err, 2'b00);
      reset = 1'b0;

      issue(0, 7'h50, 8'h10, 8'hA5, 0, 8'h00, 0);
      issue(1, 7'h50, 8'h22, 8'h00, 0, 8'h3C, 0);
      issue(0, 7'h11, 8'h05, 8'h77, 1, 8'h00, 0);
      issue(0, 7'h2A, 8'h40, 8'h99, 3, 8'h00, 0);
      issue(1, 7'h33, 8'h01, 8'h00, 3, 8'h5A, 0);
      issue(1, 7'h33, 8'h02, 8'h00, 2, 8'h5A, 0);
      for (int i = 0; i < 30; i++) begin
         int nk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         issue(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), nk, 8'($urandom), 0);
      end
      drain("drain_random");

      hang = 1'b1;
      issue(0, 7'h44, 8'h12, 8'h34, 0, 8'h00, 1);
      drain("drain_timeout");
      repeat (5) @(negedge clk);
      check("timeout_no_stop", exp_trace.size(), 0);
      reset = 1'b1; @(negedge clk); reset = 1'b0; hang = 1'b0;

      force_delay = 8;
      issue(1, 7'h50, 8'h22, 8'h00, 0, 8'hC3, 0);
      t = 0;
      while (!restart_busy && t < 3000) begin @(negedge clk); t++; end
      check("restart_reached", restart_busy, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_req_ready", req_ready, 1'b1);
      check("midrst_m_write", m_write, 1'b0);
      check("midrst_resp_valid", resp_valid, 1'b0);
      check("midrst_err", err, 2'b00);
      exp_trace.delete(); exp_resp.delete();
      reset = 1'b0; force_delay = 0;
      issue(0, 7'h50, 8'h10, 8'hA5, 0, 8'h00, 0);
      drain("drain_after_reset");
      repeat (5) @(negedge clk);
      check("trace_empty_end", exp_trace.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
